// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit pipeline.
// Owns the PC, issues fetches over a ready-based handshake, and loads the IF/ID
// register. A one-entry skid buffer absorbs a response that lands while decode
// is stalled. Fetch stops on HALT and resumes only after a redirect or reset.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   imem_req/addr    fetch request valid / fetch address (always the PC)
//   imem_ready/data  response valid for the current address / instruction
//   stall            decode cannot accept; IF/ID holds
//   redirect/_pc     taken branch; refetch from redirect_pc (bit 0 dropped)
//   ifid_*           IF/ID pipeline register: valid, instr, pc, pc+2
//   halted           HALT fetched, fetch stopped
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus2,
    output logic        halted
);

    localparam int unsigned XLEN = 16;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]      state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] skid_instr, skid_instr_n;
    logic [XLEN-1:0] skid_pc, skid_pc_n;
    logic            ifid_valid_n;
    logic [XLEN-1:0] ifid_instr_n, ifid_pc_n, ifid_pc_plus2_n;
    logic            imem_req_n, halted_n;

    logic            accept_c;
    logic            data_halt_c;
    logic            skid_halt_c;
    logic [XLEN-1:0] pc_inc_c;
    logic [XLEN-1:0] skid_pc_inc_c;

    // A response counts only while a request is actually outstanding.
    assign accept_c      = imem_req & imem_ready;
    assign data_halt_c   = (imem_data[15:12] == HALT_OPCODE);
    assign skid_halt_c   = (skid_instr[15:12] == HALT_OPCODE);
    assign pc_inc_c      = pc + XLEN'(2);
    assign skid_pc_inc_c = skid_pc + XLEN'(2);
    assign imem_addr     = pc;

    // Next-state and datapath selection; priority redirect > stall > fetch.
    always_comb begin
        state_n         = state;
        pc_n            = pc;
        skid_instr_n    = skid_instr;
        skid_pc_n       = skid_pc;
        ifid_valid_n    = ifid_valid;
        ifid_instr_n    = ifid_instr;
        ifid_pc_n       = ifid_pc;
        ifid_pc_plus2_n = ifid_pc_plus2;

        if (redirect) begin
            // Flush IF/ID and skid; any same-cycle response is dropped.
            pc_n         = redirect_pc & 16'hFFFE;
            ifid_valid_n = 1'b0;
            skid_instr_n = '0;
            skid_pc_n    = '0;
            state_n      = ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (accept_c) begin
                        pc_n = data_halt_c ? pc : pc_inc_c;
                        if (!stall) begin
                            ifid_valid_n    = 1'b1;
                            ifid_instr_n    = imem_data;
                            ifid_pc_n       = pc;
                            ifid_pc_plus2_n = pc_inc_c;
                            state_n         = data_halt_c ? ST_HALTED : ST_FETCH;
                        end else begin
                            skid_instr_n = imem_data;
                            skid_pc_n    = pc;
                            state_n      = ST_HOLD;
                        end
                    end else if (!stall) begin
                        ifid_valid_n = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_valid_n    = 1'b1;
                        ifid_instr_n    = skid_instr;
                        ifid_pc_n       = skid_pc;
                        ifid_pc_plus2_n = skid_pc_inc_c;
                        skid_instr_n    = '0;
                        skid_pc_n       = '0;
                        state_n         = skid_halt_c ? ST_HALTED : ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    if (!stall) begin
                        ifid_valid_n = 1'b0;
                    end
                end
                default: begin
                    state_n = ST_FETCH;
                end
            endcase
        end

        imem_req_n = (state_n == ST_FETCH);
        halted_n   = (state_n == ST_HALTED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_FETCH;
            pc            <= RESET_PC;
            skid_instr    <= '0;
            skid_pc       <= '0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus2 <= '0;
            imem_req      <= 1'b0;
            halted        <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            skid_instr    <= skid_instr_n;
            skid_pc       <= skid_pc_n;
            ifid_valid    <= ifid_valid_n;
            ifid_instr    <= ifid_instr_n;
            ifid_pc       <= ifid_pc_n;
            ifid_pc_plus2 <= ifid_pc_plus2_n;
            imem_req      <= imem_req_n;
            halted        <= halted_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Memory returns 16'h1000 + addr, except a
// HALT word (16'hF000) at halt_addr.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus2;
    logic        halted;

    logic [15:0] halt_addr;
    int          total;
    int          bad;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .halted        (halted)
    );

    assign imem_data = (imem_addr == halt_addr) ? 16'hF000 : 16'h1000 + imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic v, input logic [15:0] instr,
                            input logic [15:0] pc);
        check({tag, ".valid"}, 16'(ifid_valid), 16'(v));
        check({tag, ".instr"}, ifid_instr, instr);
        check({tag, ".pc"}, ifid_pc, pc);
        check({tag, ".pc2"}, ifid_pc_plus2, pc + 16'd2);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt_addr   = 16'hFFFF;

        // Reset values
        #12;
        check("rst.req", 16'(imem_req), 16'd0);
        check("rst.addr", imem_addr, 16'h0000);
        check("rst.valid", 16'(ifid_valid), 16'd0);
        check("rst.instr", ifid_instr, 16'h0000);
        check("rst.pc2", ifid_pc_plus2, 16'h0000);
        check("rst.halted", 16'(halted), 16'd0);
        rst_n      = 1'b1;
        imem_ready = 1'b1;

        // Zero-wait streaming
        step();
        check("s1.req", 16'(imem_req), 16'd1);
        check("s1.addr", imem_addr, 16'h0000);
        check("s1.valid", 16'(ifid_valid), 16'd0);
        step();
        check("s2.addr", imem_addr, 16'h0002);
        check_if("s2", 1'b1, 16'h1000, 16'h0000);
        step();
        check("s3.addr", imem_addr, 16'h0004);
        check_if("s3", 1'b1, 16'h1002, 16'h0002);

        // Three wait states at 0x0004
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("w.addr", imem_addr, 16'h0004);
            check("w.req", 16'(imem_req), 16'd1);
            check("w.valid", 16'(ifid_valid), 16'd0);
        end
        imem_ready = 1'b1;
        step();
        check("w4.addr", imem_addr, 16'h0006);
        check_if("w4", 1'b1, 16'h1004, 16'h0004);
        step();
        check_if("w5", 1'b1, 16'h1006, 16'h0006);
        check("w5.addr", imem_addr, 16'h0008);

        // Stall while 0x0008 response arrives -> skid
        stall = 1'b1;
        step();
        check_if("k1", 1'b1, 16'h1006, 16'h0006);
        check("k1.req", 16'(imem_req), 16'd0);
        step();
        check_if("k2", 1'b1, 16'h1006, 16'h0006);
        check("k2.req", 16'(imem_req), 16'd0);
        stall = 1'b0;
        step();
        check_if("k3", 1'b1, 16'h1008, 16'h0008);
        check("k3.req", 16'(imem_req), 16'd1);
        check("k3.addr", imem_addr, 16'h000A);
        step();
        check_if("k4", 1'b1, 16'h100A, 16'h000A);

        // Redirect with stall and ready: redirect wins, response dropped
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        stall       = 1'b1;
        step();
        check("r1.valid", 16'(ifid_valid), 16'd0);
        check("r1.addr", imem_addr, 16'h0040);
        check("r1.req", 16'(imem_req), 16'd1);
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        check_if("r2", 1'b1, 16'h1040, 16'h0040);

        // HALT at 0x0010
        halt_addr   = 16'h0010;
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        step();
        check("h0.addr", imem_addr, 16'h0010);
        redirect = 1'b0;
        step();
        check_if("h1", 1'b1, 16'hF000, 16'h0010);
        check("h1.halted", 16'(halted), 16'd1);
        check("h1.req", 16'(imem_req), 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("h.req", 16'(imem_req), 16'd0);
            check("h.halted", 16'(halted), 16'd1);
            check("h.valid", 16'(ifid_valid), 16'd0);
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        step();
        check("h5.halted", 16'(halted), 16'd0);
        check("h5.req", 16'(imem_req), 16'd1);
        check("h5.addr", imem_addr, 16'h0020);
        redirect = 1'b0;
        step();
        check_if("h6", 1'b1, 16'h1020, 16'h0020);

        // PC wrap at 0xFFFE
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        check("p0.addr", imem_addr, 16'hFFFE);
        redirect = 1'b0;
        step();
        check_if("p1", 1'b1, 16'h0FFE, 16'hFFFE);
        check("p1.pc2", ifid_pc_plus2, 16'h0000);
        check("p1.addr", imem_addr, 16'h0000);
        step();
        check_if("p2", 1'b1, 16'h1000, 16'h0000);

        // Asynchronous reset during a wait state with IF/ID held
        imem_ready = 1'b0;
        stall      = 1'b1;
        step();
        check("a0.addr", imem_addr, 16'h0002);
        check_if("a0", 1'b1, 16'h1000, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("a1.req", 16'(imem_req), 16'd0);
        check("a1.addr", imem_addr, 16'h0000);
        check("a1.valid", 16'(ifid_valid), 16'd0);
        check("a1.instr", ifid_instr, 16'h0000);
        check("a1.pc", ifid_pc, 16'h0000);
        check("a1.pc2", ifid_pc_plus2, 16'h0000);
        check("a1.halted", 16'(halted), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipeline.
- Owns the PC register and issues fetches to instruction memory over a ready-based handshake.
- Loads the IF/ID pipeline register (instruction, PC, PC+2). The PC+2 value is what the branch-resolution logic adds the branch offset to.
- Accepts a redirect from branch resolution, holds on hazard stalls, and stops fetching on HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- HALT_OPCODE, 4'hF, opcode in instr[15:12] that stops fetch.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  16  fetch address, always equals the PC register.
- imem_ready  input  1  imem_data valid for current imem_addr this cycle.
- imem_data  input  16  fetched instruction.
- stall  input  1  decode cannot accept; IF/ID must hold.
- redirect  input  1  taken branch/jump resolved; refetch from redirect_pc.
- redirect_pc  input  16  branch target (bit 0 forced to 0 internally).
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  16  instruction in IF/ID.
- ifid_pc  output  16  address of ifid_instr.
- ifid_pc_plus2  output  16  ifid_pc + 2, modulo 2^16.
- halted  output  1  HALT fetched, fetch stopped.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - pc=RESET_PC, state=FETCH.
  - ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus2=0.
  - Skid buffer empty, halted=0, imem_req=0 until first clock after deassertion.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: response captured in 1-entry skid buffer, decode stalled, imem_req=0.
  - HALTED: imem_req=0, halted=1.
- Memory contract:
  - imem_addr is stable while imem_req=1 until imem_ready.
  - A redirect may change the address, which aborts the outstanding fetch.
  - imem_ready is ignored when imem_req=0.
- Priority: reset > redirect > stall > normal fetch.
- Redirect (any state):
  - pc <= {redirect_pc[15:1],1'b0}.
  - ifid_valid <= 0, skid buffer cleared.
  - Any imem_data arriving the same cycle is discarded.
  - state <= FETCH, halted <= 0.
  - Fetch resumes next cycle, so a taken branch costs a minimum 1-cycle bubble.
- FETCH, imem_ready=1, stall=0:
  - IF/ID <= {1, imem_data, pc, pc+2}.
  - If opcode==HALT_OPCODE: pc holds and state <= HALTED. The HALT instruction itself is delivered to IF/ID.
  - Otherwise pc <= pc+2.
- FETCH, imem_ready=1, stall=1:
  - IF/ID holds.
  - Skid buffer <= {imem_data, pc}.
  - pc <= pc+2, or holds if HALT.
  - state <= HOLD.
- FETCH, imem_ready=0:
  - stall=0: ifid_valid <= 0 (bubble).
  - stall=1: IF/ID holds.
- HOLD, stall=0:
  - IF/ID <= skid contents, skid cleared.
  - state <= HALTED if the skid instruction is HALT, else FETCH.
- HOLD, stall=1: everything holds.
- HALTED, stall=0: ifid_valid <= 0 after the HALT leaves IF/ID. Exit only by redirect or reset.
- PC arithmetic:
  - Unsigned 16-bit wrap: 16'hFFFE + 2 = 16'h0000, with no flag or error.
  - PC bit 0 is always 0.
- Latency: imem_ready at edge N puts the instruction on ifid_* after edge N.
- Throughput: with a zero-wait memory, one instruction per cycle.
- Simultaneous redirect+stall: redirect wins; IF/ID is flushed despite the stall.
- Simultaneous redirect+imem_ready: the response is dropped.

Test Plan:
- Reset, zero-wait memory returning 16'h1000+addr, stall=0 -> imem_addr 0,2,4,6 on consecutive cycles; ifid_pc lags by one cycle; ifid_pc_plus2=ifid_pc+2; ifid_valid=1 from the second cycle.
- imem_ready delayed 3 cycles at addr 0x0004 -> imem_addr held at 0x0004 with imem_req=1 for 3 cycles; ifid_valid=0 for those cycles; instr delivered with ifid_pc=0x0004.
- stall=1 for 2 cycles while the response for 0x0008 arrives -> IF/ID holds the 0x0006 instr; state HOLD with imem_req=0; on stall release ifid_pc=0x0008, then fetch resumes at 0x000A.
- redirect=1 with redirect_pc=0x0041 while imem_ready=1 and stall=1 -> next cycle ifid_valid=0, imem_addr=0x0040; the dropped instr never appears on ifid_*.
- Fetch 16'hF000 at 0x0010 -> ifid_instr=16'hF000; halted=1; imem_req=0 indefinitely. Then redirect to 0x0020 -> halted=0 and fetch at 0x0020.
- Start pc=0xFFFE via redirect -> next imem_addr=0x0000. Separately, assert rst_n=0 mid-wait-state -> all outputs zero immediately, without waiting for a clock edge.
